// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the pipelined immediate generator.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_SHAMT,
    IMM_ZIMM
  } imm_fmt_e;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_TWO
  } buf_state_e;

  localparam int unsigned INSTR_W = 32;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

endpackage

// File: rtl/imm_gen_stage_extract.sv
// Combinational immediate extraction: raw instruction -> XLEN immediate and format tag.
module imm_extract
  import imm_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter bit          RV64_W = 1'b1,
  parameter bit          ZICSR  = 1'b1
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    imm,
  output imm_fmt_e           fmt
);

  localparam int unsigned SHAMT_W = (XLEN == 64) ? 6 : 5;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_shift;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    imm = '0;
    fmt = IMM_NONE;
    unique case (opcode)
      OPC_LOAD, OPC_JALR: begin
        imm = XLEN'($signed(instr[31:20]));
        fmt = IMM_I;
      end
      OPC_OP_IMM: begin
        if (is_shift) begin
          imm = XLEN'(instr[20 +: SHAMT_W]);
          fmt = IMM_SHAMT;
        end else begin
          imm = XLEN'($signed(instr[31:20]));
          fmt = IMM_I;
        end
      end
      // *W shifts only ever take a 5-bit amount, even on RV64
      OPC_OP_IMM_32: begin
        if ((XLEN == 64) && RV64_W) begin
          if (is_shift) begin
            imm = XLEN'(instr[24:20]);
            fmt = IMM_SHAMT;
          end else begin
            imm = XLEN'($signed(instr[31:20]));
            fmt = IMM_I;
          end
        end
      end
      OPC_STORE: begin
        imm = XLEN'($signed({instr[31:25], instr[11:7]}));
        fmt = IMM_S;
      end
      OPC_BRANCH: begin
        imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
        fmt = IMM_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm = XLEN'($signed({instr[31:12], 12'b0}));
        fmt = IMM_U;
      end
      OPC_JAL: begin
        imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
        fmt = IMM_J;
      end
      OPC_SYSTEM: begin
        if (ZICSR && funct3[2]) begin
          imm = XLEN'(instr[19:15]);
          fmt = IMM_ZIMM;
        end
      end
      default: begin
        imm = '0;
        fmt = IMM_NONE;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator: decode on input, 2-entry skid buffer (M head, S skid) on output.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter bit          RV64_W = 1'b1,
  parameter bit          ZICSR  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_imm,
  output imm_fmt_e           out_fmt
);

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;

  imm_extract #(
    .XLEN   (XLEN),
    .RV64_W (RV64_W),
    .ZICSR  (ZICSR)
  ) u_extract (
    .instr (in_instr),
    .imm   (dec_imm),
    .fmt   (dec_fmt)
  );

  buf_state_e         state_q, state_d;
  logic [INSTR_W-1:0] m_instr_q, m_instr_d, s_instr_q, s_instr_d;
  logic [XLEN-1:0]    m_imm_q, m_imm_d, s_imm_q, s_imm_d;
  imm_fmt_e           m_fmt_q, m_fmt_d, s_fmt_q, s_fmt_d;
  logic               push, pop;

  assign in_ready  = (state_q != BUF_TWO);
  assign out_valid = (state_q != BUF_EMPTY);
  assign out_instr = m_instr_q;
  assign out_imm   = m_imm_q;
  assign out_fmt   = m_fmt_q;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BUF_EMPTY;
      m_instr_q <= '0;
      m_imm_q   <= '0;
      m_fmt_q   <= IMM_NONE;
      s_instr_q <= '0;
      s_imm_q   <= '0;
      s_fmt_q   <= IMM_NONE;
    end else begin
      state_q   <= state_d;
      m_instr_q <= m_instr_d;
      m_imm_q   <= m_imm_d;
      m_fmt_q   <= m_fmt_d;
      s_instr_q <= s_instr_d;
      s_imm_q   <= s_imm_d;
      s_fmt_q   <= s_fmt_d;
    end
  end

  // Flush only resets occupancy; stale payload is invisible once out_valid drops
  always_comb begin
    state_d   = state_q;
    m_instr_d = m_instr_q;
    m_imm_d   = m_imm_q;
    m_fmt_d   = m_fmt_q;
    s_instr_d = s_instr_q;
    s_imm_d   = s_imm_q;
    s_fmt_d   = s_fmt_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      unique case (state_q)
        BUF_EMPTY: begin
          if (push) begin
            m_instr_d = in_instr;
            m_imm_d   = dec_imm;
            m_fmt_d   = dec_fmt;
            state_d   = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (push && pop) begin
            m_instr_d = in_instr;
            m_imm_d   = dec_imm;
            m_fmt_d   = dec_fmt;
          end else if (push) begin
            s_instr_d = in_instr;
            s_imm_d   = dec_imm;
            s_fmt_d   = dec_fmt;
            state_d   = BUF_TWO;
          end else if (pop) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          if (pop) begin
            m_instr_d = s_instr_q;
            m_imm_d   = s_imm_q;
            m_fmt_d   = s_fmt_q;
            state_d   = BUF_ONE;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage: vector table, scoreboard queue, back-pressure/flush/reset sequences.
module tb_imm_gen_stage;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_imm;
  imm_fmt_e    out_fmt;

  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [31:0] in_instr64 = '0;
  logic        out_valid64;
  logic [31:0] out_instr64;
  logic [63:0] out_imm64;
  imm_fmt_e    out_fmt64;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_imm(out_imm), .out_fmt(out_fmt)
  );

  imm_gen_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64),
    .out_valid(out_valid64), .out_ready(1'b1),
    .out_instr(out_instr64), .out_imm(out_imm64), .out_fmt(out_fmt64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    imm_fmt_e    fmt;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    imm_fmt_e    fmt;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Reference decode built from shifts of the sign-extended word
  function automatic exp_t model(input logic [31:0] ins, input bit x64);
    exp_t   e;
    longint s;
    logic [2:0] f3;
    s = longint'($signed(ins));
    f3 = ins[14:12];
    e.instr = ins;
    e.imm = 64'd0;
    e.fmt = IMM_NONE;
    case (ins[6:0])
      7'h03, 7'h67: begin e.imm = s >>> 20; e.fmt = IMM_I; end
      7'h13: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.imm = (s >> 20) & (x64 ? 64'd63 : 64'd31); e.fmt = IMM_SHAMT;
        end else begin
          e.imm = s >>> 20; e.fmt = IMM_I;
        end
      end
      7'h1B: begin
        if (x64) begin
          if (f3 == 3'd1 || f3 == 3'd5) begin e.imm = (s >> 20) & 64'd31; e.fmt = IMM_SHAMT; end
          else begin e.imm = s >>> 20; e.fmt = IMM_I; end
        end
      end
      7'h23: begin e.imm = ((s >>> 25) << 5) | ((s >> 7) & 64'd31); e.fmt = IMM_S; end
      7'h63: begin
        e.imm = ((s >>> 31) << 12) | (((s >> 7) & 64'd1) << 11) |
                (((s >> 25) & 64'd63) << 5) | (((s >> 8) & 64'd15) << 1);
        e.fmt = IMM_B;
      end
      7'h37, 7'h17: begin e.imm = s & ~64'hFFF; e.fmt = IMM_U; end
      7'h6F: begin
        e.imm = ((s >>> 31) << 20) | (((s >> 12) & 64'd255) << 12) |
                (((s >> 20) & 64'd1) << 11) | (((s >> 21) & 64'd1023) << 1);
        e.fmt = IMM_J;
      end
      7'h73: begin
        if (f3[2]) begin e.imm = (s >> 15) & 64'd31; e.fmt = IMM_ZIMM; end
      end
      default: ;
    endcase
    if (!x64) e.imm = {32'd0, e.imm[31:0]};
    return e;
  endfunction

  // One cycle on the 32-bit DUT: score the handshakes that the coming edge will complete
  task automatic tick(input exp_t e);
    exp_t x;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'(out_instr), 64'hDEAD_BEEF);
        end else begin
          x = exp_q.pop_front();
          chk("out_instr", 64'(out_instr), 64'(x.instr));
          chk("out_imm", 64'(out_imm), x.imm);
          chk("out_fmt", 64'(out_fmt), 64'(x.fmt));
          pops++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_imm"}, 64'(out_imm), 64'd0);
    chk({tag, "_out_instr"}, 64'(out_instr), 64'd0);
    chk({tag, "_out_fmt"}, 64'(out_fmt), 64'(IMM_NONE));
  endtask

  vec_t        tab[8];
  vec_t        tab64[4];
  logic [31:0] bp[4];
  logic [6:0]  ops[10];
  logic [31:0] r;
  exp_t        te;
  int          idx;
  bit          acc;

  initial begin
    tab[0] = '{32'hFFF00093, 64'hFFFFFFFF, IMM_I};
    tab[1] = '{32'hFE112E23, 64'hFFFFFFFC, IMM_S};
    tab[2] = '{32'hFE000CE3, 64'hFFFFFFF8, IMM_B};
    tab[3] = '{32'h123452B7, 64'h12345000, IMM_U};
    tab[4] = '{32'h001000EF, 64'h00000800, IMM_J};
    tab[5] = '{32'h4030D093, 64'h00000003, IMM_SHAMT};
    tab[6] = '{32'h3002D073, 64'h00000005, IMM_ZIMM};
    tab[7] = '{32'h00000033, 64'h00000000, IMM_NONE};
    tab64[0] = '{32'h800002B7, 64'hFFFFFFFF_80000000, IMM_U};
    tab64[1] = '{32'h03F0D093, 64'd63, IMM_SHAMT};
    tab64[2] = '{32'h0200D09B, 64'd0, IMM_SHAMT};
    tab64[3] = '{32'hFFF00093, 64'hFFFFFFFF_FFFFFFFF, IMM_I};
    ops = '{7'h03, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Spec vectors streamed back to back
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_instr = tab[i].instr;
      te = '{tab[i].instr, tab[i].imm, tab[i].fmt};
      tick(te);
    end
    in_valid = 1'b0;
    tick(te);
    chk("table_drained", 64'(exp_q.size()), 64'd0);

    // XLEN=64 instance, one instruction at a time
    for (int i = 0; i < 4; i++) begin
      in_valid64 = 1'b1;
      in_instr64 = tab64[i].instr;
      @(posedge clk);
      @(negedge clk);
      in_valid64 = 1'b0;
      chk("x64_valid", 64'(out_valid64), 64'd1);
      chk("x64_imm", out_imm64, tab64[i].imm);
      chk("x64_fmt", 64'(out_fmt64), 64'(tab64[i].fmt));
    end

    // Full throughput with random instructions
    for (int k = 0; k < 16; k++) begin
      r = $urandom();
      in_valid = 1'b1;
      in_instr = {r[31:7], ops[$urandom_range(9, 0)]};
      chk("tp_in_ready", 64'(in_ready), 64'd1);
      if (k > 0) begin
        chk("tp_out_valid", 64'(out_valid), 64'd1);
        chk("tp_latency", 64'(exp_q.size()), 64'd1);
      end
      tick(model(in_instr, 1'b0));
    end
    in_valid = 1'b0;
    tick(te);
    chk("tp_drained", 64'(exp_q.size()), 64'd0);

    // Back-pressure: two accepts, then stall, then drain without bubbles
    for (int i = 0; i < 4; i++) begin
      r = $urandom();
      bp[i] = {r[31:7], ops[$urandom_range(9, 0)]};
    end
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_instr = bp[i];
      tick(model(in_instr, 1'b0));
    end
    in_instr = bp[2];
    for (int i = 0; i < 2; i++) begin
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_hold_instr", 64'(out_instr), 64'(bp[0]));
      tick(model(in_instr, 1'b0));
    end
    out_ready = 1'b1;
    idx = 2;
    pops = 0;
    for (int c = 0; c < 20 && pops < 4; c++) begin
      in_valid = (idx < 4);
      in_instr = bp[(idx < 4) ? idx : 3];
      chk("bp_no_bubble", 64'(out_valid), 64'd1);
      acc = in_valid && in_ready;
      tick(model(in_instr, 1'b0));
      if (acc) idx++;
    end
    chk("bp_all_out", 64'(pops), 64'd4);
    in_valid = 1'b0;

    // Flush in TWO with a concurrent in_valid
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_instr = 32'h00100093 + 32'(i << 20);
      tick(model(in_instr, 1'b0));
    end
    chk("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    in_instr = 32'hABCDE0B7;
    tick(model(in_instr, 1'b0));
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00500113;
    tick(model(in_instr, 1'b0));
    in_valid = 1'b0;
    tick(te);
    chk("fl_after_empty", 64'(out_valid), 64'd0);
    chk("fl_q_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset between clock edges
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_instr = 32'hFE112E23;
      tick(model(in_instr, 1'b0));
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
